// File: rtl/dmac_iochannel_master.sv
// DMA bus initiator: splits one command into boundary- and length-limited bursts
// and moves words between a stream port and an AXI-style AW/W/B or AR/R bus.
module dmac_iochannel_master #(
  parameter int unsigned W_D           = 32,
  parameter int unsigned W_EXT_A       = 32,
  parameter int unsigned W_BOUNDARY_A  = 12,
  parameter int unsigned W_BLEN        = 8,
  parameter int unsigned MAX_BURST_LEN = 256,
  parameter int unsigned W_SIZE        = 32
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [W_EXT_A-1:0] cmd_addr,
  input  logic [W_SIZE-1:0]  cmd_size,
  output logic               done,
  output logic               err,
  input  logic               src_valid,
  output logic               src_ready,
  input  logic [W_D-1:0]     src_data,
  output logic               dst_valid,
  input  logic               dst_ready,
  output logic [W_D-1:0]     dst_data,
  output logic               awvalid,
  output logic [W_EXT_A-1:0] awaddr,
  output logic [W_BLEN-1:0]  awlen,
  input  logic               awready,
  output logic               wvalid,
  output logic [W_D-1:0]     wdata,
  output logic               wlast,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready,
  output logic               arvalid,
  output logic [W_EXT_A-1:0] araddr,
  output logic [W_BLEN-1:0]  arlen,
  input  logic               arready,
  input  logic               rvalid,
  input  logic [W_D-1:0]     rdata,
  input  logic               rlast,
  output logic               rready
);

  localparam int unsigned ADDR_LSB = $clog2(W_D / 8);
  localparam int unsigned W_ROOM   = W_BOUNDARY_A + 1;
  localparam logic [W_EXT_A-1:0] A_MASK = ~((W_EXT_A'(1) << ADDR_LSB) - W_EXT_A'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_WDATA, S_WRESP, S_AR, S_RDATA, S_NEXT
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [W_EXT_A-1:0]   addr_q, addr_d;
  logic [W_SIZE-1:0]    rem_q, rem_d;
  logic [W_BLEN-1:0]    len_q, len_d;
  logic [W_BLEN-1:0]    beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 cmd_ready_q, awvalid_q, arvalid_q, bready_q;

  logic                 last_beat;
  logic [W_SIZE-1:0]    burst_words, rem_after;
  logic [W_EXT_A-1:0]   addr_after;

  // Beats of the next burst minus one: limited by words left, max length and boundary room.
  function automatic logic [W_BLEN-1:0] burst_len_m1(input logic [W_EXT_A-1:0] a,
                                                     input logic [W_SIZE-1:0]  r);
    logic [W_ROOM-1:0] room;
    logic [W_SIZE-1:0] n;
    room = {1'b1, {W_BOUNDARY_A{1'b0}}} - {1'b0, a[W_BOUNDARY_A-1:0]};
    n    = W_SIZE'(room >> ADDR_LSB);
    if (r < n) n = r;
    if (n > W_SIZE'(MAX_BURST_LEN)) n = W_SIZE'(MAX_BURST_LEN);
    return W_BLEN'(n - W_SIZE'(1));
  endfunction

  assign last_beat   = (beat_q == len_q);
  assign burst_words = W_SIZE'(len_q) + W_SIZE'(1);
  assign rem_after   = rem_q - burst_words;
  assign addr_after  = addr_q + (W_EXT_A'(burst_words) << ADDR_LSB);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr & A_MASK;
          rem_d   = cmd_size;
          err_d   = 1'b0;
          if (cmd_size == '0) begin
            state_d = S_NEXT;
            done_d  = 1'b1;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
            len_d   = burst_len_m1(cmd_addr & A_MASK, cmd_size);
          end
        end
      end
      S_NEXT: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = write_q ? S_AW : S_AR;
          len_d   = burst_len_m1(addr_q, rem_q);
        end
      end
      S_AW: begin
        if (awready) begin
          state_d = S_WDATA;
          beat_d  = '0;
        end
      end
      S_AR: begin
        if (arready) begin
          state_d = S_RDATA;
          beat_d  = '0;
        end
      end
      S_WDATA: begin
        if (src_valid && wready) begin
          if (last_beat) state_d = S_WRESP;
          else           beat_d  = beat_q + W_BLEN'(1);
        end
      end
      S_WRESP: begin
        if (bvalid) begin
          addr_d  = addr_after;
          rem_d   = rem_after;
          state_d = S_NEXT;
          done_d  = (rem_after == '0);
        end
      end
      S_RDATA: begin
        if (rvalid && dst_ready) begin
          // rlast is only cross-checked; the beat counter ends the burst.
          if (rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            addr_d  = addr_after;
            rem_d   = rem_after;
            state_d = S_NEXT;
            done_d  = (rem_after == '0);
          end else begin
            beat_d = beat_q + W_BLEN'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      done_q      <= done_d;
      cmd_ready_q <= (state_d == S_IDLE);
      awvalid_q   <= (state_d == S_AW);
      arvalid_q   <= (state_d == S_AR);
      bready_q    <= (state_d == S_WRESP);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign awvalid   = awvalid_q;
  assign arvalid   = arvalid_q;
  assign bready    = bready_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awlen     = len_q;
  assign arlen     = len_q;

  // Zero-latency stream pass-through while a data phase is active.
  assign wvalid    = (state_q == S_WDATA) & src_valid;
  assign wdata     = src_data;
  assign wlast     = (state_q == S_WDATA) & last_beat;
  assign src_ready = (state_q == S_WDATA) & wready;
  assign dst_valid = (state_q == S_RDATA) & rvalid;
  assign dst_data  = rdata;
  assign rready    = (state_q == S_RDATA) & dst_ready;

endmodule

// File: tb/tb_dmac_iochannel_master.sv
// Bench for dmac_iochannel_master: vector table, corner sequences and random commands
// against a burst-splitting model and bus/stream responders kept in the bench.
module tb_dmac_iochannel_master;

  logic        ACLK, ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_size;
  logic        done, err;
  logic        src_valid, src_ready;
  logic [31:0] src_data;
  logic        dst_valid, dst_ready;
  logic [31:0] dst_data;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic        arvalid, arready, rvalid, rlast, rready;

  dmac_iochannel_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rnd(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rlast = 1'b0;
  endtask

  // Runs one command against bus/stream responders; rst_at>=0 resets after that many W beats.
  task automatic run_cmd(input bit wr, input logic [31:0] a, input int size, input int pct,
                         input int bad_rlast, input int rst_at,
                         output int nb, output logic [31:0] fa, output int fl,
                         output logic err_end, output logic err_acc, output logic err_post);
    logic [31:0] ea[$];
    int          el[$];
    longint unsigned m_addr;
    longint      m_rem, m_room, m_n;
    logic [31:0] base;
    int cyc = 0, acc_cyc = -10, done_due = -10;
    int words = 0, src_idx = 0, wbeat = 0, cur_len = 0;
    int rd_pend = 0, rd_word = 0, b_delay = 0, spur = 0, proto = 0;
    bit accepted = 0, finished = 0, aborted = 0, b_pending = 0, in_wr = 0, in_rd = 0;

    // Reference burst list from plain arithmetic on the command.
    m_addr = longint'(a & 32'hFFFF_FFFC);
    m_rem  = longint'(size);
    while (m_rem > 0) begin
      m_room = longint'((4096 - (m_addr % 4096)) / 4);
      m_n = m_rem;
      if (m_n > 256) m_n = 256;
      if (m_n > m_room) m_n = m_room;
      ea.push_back(32'(m_addr));
      el.push_back(int'(m_n - 1));
      m_addr = (m_addr + longint'(m_n) * 4) % (64'd1 << 32);
      m_rem  = m_rem - m_n;
    end

    base = $urandom;
    nb = 0; fa = '0; fl = -1; err_end = 1'b0; err_acc = 1'b0; err_post = 1'b0;
    @(negedge ACLK);
    while (!finished && cyc < 20000) begin
      if (rst_at >= 0 && words == rst_at) begin
        ARESETN = 1'b0;
        #1;
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_done", done, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        finished = 1; aborted = 1;
      end else begin
        cmd_valid = accepted ? ($urandom_range(0, 3) == 0) : 1'b1;
        cmd_write = accepted ? 1'($urandom) : wr;
        cmd_addr  = accepted ? $urandom : a;
        cmd_size  = accepted ? $urandom : 32'(size);
        awready   = rnd(pct);
        arready   = rnd(pct);
        wready    = rnd(pct);
        dst_ready = rnd(pct);
        src_valid = (src_idx < size) ? rnd(pct) : 1'b0;
        src_data  = base + 32'(src_idx);
        if (b_pending && b_delay == 0) bvalid = 1'b1;
        else begin
          bvalid = 1'b0;
          if (b_pending) b_delay--;
        end
        rvalid = (rd_pend > 0) ? rnd(pct) : 1'b0;
        rdata  = base + 32'(rd_word);
        rlast  = (bad_rlast >= 0) ? (rd_word == bad_rlast) : (rd_pend == 1);
        #1;

        if (cyc == done_due) begin
          check("done_timing", done, 1);
          err_end  = err;
          finished = 1;
        end else if (done) spur++;
        if (awvalid && (!wr || !accepted || ea.size() == 0)) spur++;
        if (arvalid && (wr || !accepted || ea.size() == 0)) spur++;
        if (wvalid !== (in_wr & src_valid) || src_ready !== (in_wr & wready)) proto++;
        if (dst_valid !== (in_rd & rvalid) || rready !== (in_rd & dst_ready)) proto++;
        if (bready !== b_pending) proto++;

        if (cmd_valid && cmd_ready) begin
          if (accepted) spur++;
          else begin
            accepted = 1; acc_cyc = cyc; err_acc = err;
            if (size == 0) done_due = cyc + 1;
          end
        end
        if (cyc == acc_cyc + 1) begin
          err_post = err;
          if (size > 0) check("valid_rise", wr ? awvalid : arvalid, 1);
        end

        if (awvalid && awready && wr && ea.size() > 0) begin
          check("awaddr", awaddr, ea[0]);
          check("awlen", awlen, el[0]);
          if (nb == 0) begin fa = awaddr; fl = int'(awlen); end
          nb++; cur_len = el[0]; wbeat = 0; in_wr = 1;
          void'(ea.pop_front()); void'(el.pop_front());
        end
        if (arvalid && arready && !wr && ea.size() > 0) begin
          check("araddr", araddr, ea[0]);
          check("arlen", arlen, el[0]);
          if (nb == 0) begin fa = araddr; fl = int'(arlen); end
          nb++; rd_pend = el[0] + 1; in_rd = 1;
          void'(ea.pop_front()); void'(el.pop_front());
        end

        if (wvalid && wready) begin
          check("wdata", wdata, base + 32'(words));
          check("wlast", wlast, wbeat == cur_len);
          words++;
          if (wbeat == cur_len) begin
            in_wr = 0; b_pending = 1; b_delay = int'($urandom_range(0, 3));
          end
          wbeat++;
        end
        if (src_valid && src_ready) src_idx++;
        if (bvalid && bready) begin
          b_pending = 0;
          if (ea.size() == 0 && words >= size) done_due = cyc + 1;
        end
        if (rvalid && rready) begin
          rd_pend--; rd_word++;
          if (rd_pend == 0) in_rd = 0;
          if (rd_pend == 0 && ea.size() == 0 && rd_word >= size) done_due = cyc + 1;
        end
        if (dst_valid && dst_ready) check("dst_data", dst_data, base + 32'(rd_word - 1));

        if (!finished) begin
          @(negedge ACLK);
          cyc++;
        end
      end
    end
    if (!aborted) begin
      if (!finished) check("cmd_timeout", finished, 1);
      check("bursts_left", ea.size(), 0);
      check("beats", wr ? words : rd_word, size);
      check("spurious_activity", spur, 0);
      check("stream_protocol", proto, 0);
    end
    idle_inputs();
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          size;
    int          pct;
    int          nb;
    logic [31:0] fa;
    int          fl;
  } vec_t;

  vec_t vt[9];
  int nb, fl, dn;
  logic [31:0] fa, ra;
  logic e_end, e_acc, e_post;
  bit rw;
  int rsize;

  initial begin
    vt[0] = '{1'b1, 32'h0000_0000, 16,  100, 1, 32'h0000_0000, 15};
    vt[1] = '{1'b1, 32'h0000_0FF0, 8,   100, 2, 32'h0000_0FF0, 3};
    vt[2] = '{1'b0, 32'h0000_0000, 600, 100, 3, 32'h0000_0000, 255};
    vt[3] = '{1'b0, 32'h0000_0000, 600, 50,  3, 32'h0000_0000, 255};
    vt[4] = '{1'b1, 32'h0000_0100, 0,   100, 0, 32'h0000_0000, -1};
    vt[5] = '{1'b0, 32'h0000_0100, 0,   70,  0, 32'h0000_0000, -1};
    vt[6] = '{1'b1, 32'h0000_0FF3, 8,   60,  2, 32'h0000_0FF0, 3};
    vt[7] = '{1'b0, 32'hFFFF_FFF8, 4,   80,  2, 32'hFFFF_FFF8, 1};
    vt[8] = '{1'b1, 32'h0000_07FC, 300, 75,  2, 32'h0000_07FC, 255};

    idle_inputs();
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_awvalid", awvalid, 0);
    check("reset_arvalid", arvalid, 0);
    check("reset_wvalid", wvalid, 0);
    check("reset_bready", bready, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_awaddr", awaddr, 0);
    check("reset_awlen", awlen, 0);
    ARESETN = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cmd(vt[i].wr, vt[i].addr, vt[i].size, vt[i].pct, -1, -1, nb, fa, fl, e_end, e_acc, e_post);
      check($sformatf("vec%0d_nbursts", i), nb, vt[i].nb);
      if (vt[i].nb > 0) begin
        check($sformatf("vec%0d_first_addr", i), fa, vt[i].fa);
        check($sformatf("vec%0d_first_len", i), fl, vt[i].fl);
      end
      check($sformatf("vec%0d_err", i), e_end, 0);
    end

    // rlast on beat 3 of 4 flags err, which holds until the next command is accepted.
    run_cmd(1'b0, 32'h40, 4, 100, 2, -1, nb, fa, fl, e_end, e_acc, e_post);
    check("rlast_err_set", e_end, 1);
    repeat (3) @(negedge ACLK);
    #1;
    check("err_sticky", err, 1);
    run_cmd(1'b1, 32'h80, 2, 100, -1, -1, nb, fa, fl, e_end, e_acc, e_post);
    check("err_at_accept", e_acc, 1);
    check("err_cleared", e_post, 0);
    check("err_after_clean", e_end, 0);

    // Reset during beat 5 of a write, then a normal command.
    run_cmd(1'b1, 32'h0, 16, 100, -1, 4, nb, fa, fl, e_end, e_acc, e_post);
    @(negedge ACLK);
    ARESETN = 1'b1;
    dn = 0;
    repeat (5) begin
      @(negedge ACLK);
      #1;
      if (done) dn++;
    end
    check("no_done_after_reset", dn, 0);
    run_cmd(1'b1, 32'h0, 16, 80, -1, -1, nb, fa, fl, e_end, e_acc, e_post);
    check("post_reset_nbursts", nb, 1);
    check("post_reset_len", fl, 15);

    for (int i = 0; i < 20; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      rsize = int'($urandom_range(0, 200));
      run_cmd(rw, ra, rsize, int'($urandom_range(50, 100)), -1, -1, nb, fa, fl, e_end, e_acc, e_post);
      if (!rw) check($sformatf("rand%0d_err", i), e_end, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
